// File: rtl/orb_chan_packer.sv
// Round-robin packer: pops bytes from CH channel FIFOs and writes 12-bit orbit words
// into each channel's slot region of the ping-pong bank that M16 is not reading.
module orb_chan_packer #(
    parameter int CH     = 5,
    parameter int SLOTS  = 32,
    parameter int AW     = 11,
    parameter int BASE0  = 0,
    parameter int STRIDE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   chanEn,
    input  logic [CH-1:0]   empty,
    input  logic [CH*8-1:0] fData,
    output logic [CH-1:0]   rdreq,
    input  logic            SW,
    output logic            WE,
    output logic [AW-1:0]   wAddr,
    output logic [11:0]     orbWord,
    output logic            bank,
    output logic [CH-1:0]   ovf,
    output logic            busy
);

    localparam int GW = (CH > 1) ? $clog2(CH) : 1;
    localparam int CW = $clog2(SLOTS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WR
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   gch_q, gch_d;
    logic            wbank_q, wbank_d;
    logic            sw_q;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [11:0]     word_q, word_d;
    logic            bank_q, bank_d;
    logic [CH-1:0]   ovf_q, ovf_d;
    logic [CH-1:0]   acc_q, acc_d;

    logic            frame_edge;
    logic [CH-1:0]   ready;
    logic            found;
    logic [GW-1:0]   pick;
    logic [CH-1:0]   rdreq_c;
    logic [CH-1:0]   cnt_inc;
    logic [CH-1:0]   ovf_hit;
    logic [CW-1:0]   cnt_all [CH];
    logic [7:0]      fbyte   [CH];
    logic [CW-1:0]   cur_cnt;
    logic [7:0]      cur_byte;
    logic            slot_free;

    assign frame_edge = (sw_q != SW);
    assign ready      = chanEn & ~empty;
    assign cur_cnt    = cnt_all[gch_q];
    assign cur_byte   = fbyte[gch_q];
    assign slot_free  = (cur_cnt < CW'(SLOTS));

    // Per-channel slot counters; a frame edge clears them and beats a same-cycle increment.
    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else if (frame_edge) begin
                cnt_q <= '0;
            end else if (cnt_inc[gi]) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end

        assign cnt_all[gi] = cnt_q;
        assign fbyte[gi]   = fData[8*gi +: 8];
    end

    // Rotating priority search starting one past the last granted channel.
    always_comb begin
        logic [GW:0] sum;
        logic [GW-1:0] idx;
        found = 1'b0;
        pick  = ptr_q;
        sum   = '0;
        idx   = '0;
        for (int k = 1; k <= CH; k++) begin
            sum = {1'b0, ptr_q} + (GW+1)'(k);
            if (sum >= (GW+1)'(CH)) begin
                sum = sum - (GW+1)'(CH);
            end
            idx = sum[GW-1:0];
            if (!found && ready[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gch_d   = gch_q;
        wbank_d = wbank_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        word_d  = word_q;
        bank_d  = bank_q;
        rdreq_c = '0;
        cnt_inc = '0;
        ovf_hit = '0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    rdreq_c[pick] = 1'b1;
                    gch_d         = pick;
                    wbank_d       = ~SW;
                    ptr_d         = pick;
                    state_d       = ST_WAIT;
                end
            end
            // FIFO data is valid here; the slot is claimed now so an edge in this cycle
            // still sees the pre-clear count and the write completes to the old frame.
            ST_WAIT: begin
                state_d = ST_WR;
                if (slot_free) begin
                    we_d           = 1'b1;
                    waddr_d        = AW'(BASE0) + AW'(int'(gch_q) * STRIDE) + AW'(cur_cnt);
                    word_d         = {1'b0, cur_byte, 3'b000};
                    bank_d         = wbank_q;
                    cnt_inc[gch_q] = 1'b1;
                end else begin
                    ovf_hit[gch_q] = 1'b1;
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Overflow seen in the edge cycle belongs to the frame that just closed.
    always_comb begin
        if (frame_edge) begin
            ovf_d = acc_q | ovf_hit;
            acc_d = '0;
        end else begin
            ovf_d = ovf_q;
            acc_d = acc_q | ovf_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= GW'(CH - 1);
            gch_q   <= '0;
            wbank_q <= 1'b0;
            sw_q    <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            word_q  <= '0;
            bank_q  <= 1'b0;
            ovf_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gch_q   <= gch_d;
            wbank_q <= wbank_d;
            sw_q    <= SW;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            word_q  <= word_d;
            bank_q  <= bank_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
        end
    end

    // The pop strobe is combinational from the FIFO flags, so hold it low during reset.
    assign rdreq   = rst ? rdreq_c : '0;
    assign WE      = we_q;
    assign wAddr   = waddr_q;
    assign orbWord = word_q;
    assign bank    = bank_q;
    assign ovf     = ovf_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_orb_chan_packer.sv
// Bench for orb_chan_packer: FIFO environment, transaction-timeline reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_orb_chan_packer;

    localparam int CH     = 5;
    localparam int SLOTS  = 32;
    localparam int AW     = 11;
    localparam int BASE0  = 0;
    localparam int STRIDE = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     chanEn;
    logic [CH-1:0]     empty;
    logic [CH*8-1:0]   fData;
    logic [CH-1:0]     rdreq;
    logic              SW;
    logic              WE;
    logic [AW-1:0]     wAddr;
    logic [11:0]       orbWord;
    logic              bank;
    logic [CH-1:0]     ovf;
    logic              busy;

    orb_chan_packer #(
        .CH(CH), .SLOTS(SLOTS), .AW(AW), .BASE0(BASE0), .STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .chanEn(chanEn), .empty(empty), .fData(fData),
        .rdreq(rdreq), .SW(SW), .WE(WE), .wAddr(wAddr), .orbWord(orbWord),
        .bank(bank), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // stimulus
    logic          rst_v;
    logic          sw_v;
    logic [CH-1:0] en_v;

    // FIFO environment
    logic [7:0] fmem [CH][256];
    int         fhd  [CH];
    int         ftl  [CH];
    logic [7:0] fq_out [CH];
    bit         pend_v [CH];
    logic [7:0] pend_b [CH];

    // reference model
    int            m_ptr;
    int            m_cnt [CH];
    logic [CH-1:0] m_acc, m_ovf;
    logic          m_swprev;
    logic [AW-1:0] m_addr;
    logic [11:0]   m_word;
    logic          m_bank;
    bit            t_act, t_ok, t_bank;
    int            t_age, t_ch;
    logic [7:0]    t_byte;

    // transaction logs
    int         gn, wn;
    int         glog_ch  [4096];
    int         glog_cyc [4096];
    int         wlog_addr[4096];
    int         wlog_word[4096];
    int         wlog_bank[4096];
    int         wlog_cyc [4096];

    function automatic int occ(int ch);
        return ftl[ch] - fhd[ch];
    endfunction

    task automatic push(int ch, logic [7:0] b);
        fmem[ch][ftl[ch] % 256] = b;
        ftl[ch]++;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic env_reset();
        for (int i = 0; i < CH; i++) begin
            fhd[i] = 0; ftl[i] = 0; fq_out[i] = 8'h00; pend_v[i] = 0; pend_b[i] = 8'h00;
        end
    endtask

    task automatic m_reset();
        m_ptr = CH - 1;
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        m_acc = '0; m_ovf = '0; m_swprev = 1'b0;
        m_addr = '0; m_word = '0; m_bank = 1'b0;
        t_act = 0; t_ok = 0; t_bank = 0; t_age = 0; t_ch = 0; t_byte = 8'h00;
    endtask

    task automatic log_clear();
        gn = 0;
        wn = 0;
    endtask

    task automatic check_cycle();
        logic [CH-1:0] ready, exp_rd, hit;
        int gp;
        bit exp_we;
        ready  = en_v & ~empty;
        exp_rd = '0;
        gp     = -1;
        if (!t_act && rst_v) begin
            for (int k = 1; k <= CH; k++) begin
                int j;
                j = (m_ptr + k) % CH;
                if (gp < 0 && ready[j]) gp = j;
            end
        end
        if (gp >= 0) exp_rd[gp] = 1'b1;
        exp_we = t_act && (t_age == 2) && t_ok;

        chk("rdreq",   32'(rdreq),   32'(exp_rd));
        chk("we",      32'(WE),      32'(exp_we));
        chk("waddr",   32'(wAddr),   32'(m_addr));
        chk("orbword", 32'(orbWord), 32'(m_word));
        chk("bank",    32'(bank),    32'(m_bank));
        chk("ovf",     32'(ovf),     32'(m_ovf));
        chk("busy",    32'(busy),    32'(t_act));

        if (rdreq != '0 && gn < 4096) begin
            for (int i = 0; i < CH; i++) if (rdreq[i]) glog_ch[gn] = i;
            glog_cyc[gn] = cyc;
            gn++;
        end
        if (WE && wn < 4096) begin
            wlog_addr[wn] = int'(wAddr);
            wlog_word[wn] = int'(orbWord);
            wlog_bank[wn] = int'(bank);
            wlog_cyc[wn]  = cyc;
            wn++;
            $display("[%0d] write addr=%0d word=%03h bank=%0d", cyc, wAddr, orbWord, bank);
        end

        if (rst_v) begin
            hit = '0;
            if (t_act && t_age == 1) begin
                if (m_cnt[t_ch] < SLOTS) begin
                    t_ok   = 1;
                    m_addr = AW'((BASE0 + t_ch * STRIDE + m_cnt[t_ch]) % (1 << AW));
                    m_word = {1'b0, t_byte, 3'b000};
                    m_bank = t_bank;
                    m_cnt[t_ch]++;
                end else begin
                    t_ok = 0;
                    hit[t_ch] = 1'b1;
                end
            end
            if (SW != m_swprev) begin
                for (int i = 0; i < CH; i++) m_cnt[i] = 0;
                m_ovf = m_acc | hit;
                m_acc = '0;
            end else begin
                m_acc = m_acc | hit;
            end
            m_swprev = SW;
            if (t_act) begin
                if (t_age == 1) t_age = 2;
                else t_act = 0;
            end else if (gp >= 0) begin
                t_act  = 1;
                t_age  = 1;
                t_ok   = 0;
                t_ch   = gp;
                t_byte = fmem[gp][fhd[gp] % 256];
                t_bank = ~SW;
                m_ptr  = gp;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst    = rst_v;
        SW     = sw_v;
        chanEn = en_v;
        for (int i = 0; i < CH; i++) begin
            if (pend_v[i]) begin
                fq_out[i] = pend_b[i];
                pend_v[i] = 0;
            end
            empty[i] = (occ(i) == 0);
            fData[8*i +: 8] = fq_out[i];
        end
        @(negedge clk);
        cyc++;
        check_cycle();
        for (int i = 0; i < CH; i++) begin
            if (rdreq[i] && occ(i) > 0) begin
                pend_b[i] = fmem[i][fhd[i] % 256];
                pend_v[i] = 1;
                fhd[i]++;
            end
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(int maxc);
        int n;
        bit pending;
        n = 0;
        pending = 1;
        while (pending && n < maxc) begin
            tick();
            n++;
            pending = t_act;
            for (int i = 0; i < CH; i++) if (occ(i) > 0) pending = 1;
        end
        chk("drain_timeout", 32'(pending), 32'd0);
    endtask

    task automatic wait_grant(int maxc);
        int n;
        n = 0;
        while (!(t_act && t_age == 1) && n < maxc) begin
            tick();
            n++;
        end
        chk("grant_timeout", 32'(t_act && t_age == 1), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0, cnt3, ch;
        env_reset();
        m_reset();
        log_clear();
        rst_v = 1'b0; sw_v = 1'b0; en_v = '1;
        rst = 1'b1; SW = 1'b0; chanEn = '1; empty = '1; fData = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_rdreq", 32'(rdreq), 32'd0);
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_waddr", 32'(wAddr), 32'd0);
        chk("rst_word", 32'(orbWord), 32'd0);
        chk("rst_bank", 32'(bank), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        run(3);
        rst_v = 1'b1;
        run(2);

        // round robin from reset: grants 0..4 three times
        log_clear();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < CH; i++) push(i, 8'($urandom));
        drain(200);
        chk("rr_grants", 32'(gn), 32'd15);
        chk("rr_writes", 32'(wn), 32'd15);
        for (int k = 0; k < 15 && k < gn; k++) chk("rr_order", 32'(glog_ch[k]), 32'(k % CH));
        for (int k = 0; k < 15 && k < wn; k++)
            chk("rr_addr", 32'(wlog_addr[k]), 32'((k % CH) * STRIDE + k / CH));

        // two frame edges, back to SW=0 with fresh counts
        sw_v = 1'b1; run(2);
        sw_v = 1'b0; run(2);

        // single byte on ch2
        log_clear();
        push(2, 8'hA5);
        drain(50);
        chk("sb_grants", 32'(gn), 32'd1);
        chk("sb_writes", 32'(wn), 32'd1);
        chk("sb_gch", 32'(glog_ch[0]), 32'd2);
        chk("sb_addr", 32'(wlog_addr[0]), 32'd128);
        chk("sb_word", 32'(wlog_word[0]), 32'h528);
        chk("sb_bank", 32'(wlog_bank[0]), 32'd1);
        chk("sb_latency", 32'(wlog_cyc[0] - glog_cyc[0]), 32'd2);

        // overflow: 34 bytes into ch0 in one frame
        sw_v = 1'b1; run(2);
        log_clear();
        for (int i = 0; i < 34; i++) push(0, 8'(i + 1));
        drain(300);
        chk("ov_grants", 32'(gn), 32'd34);
        chk("ov_writes", 32'(wn), 32'd32);
        for (int k = 0; k < 32 && k < wn; k++) chk("ov_addr", 32'(wlog_addr[k]), 32'(k));
        chk("ov_bank", 32'(wlog_bank[0]), 32'd0);
        chk("ov_before_edge", 32'(ovf), 32'd0);
        sw_v = 1'b0; run(3);
        chk("ov_flag", 32'(ovf), 32'b00001);
        sw_v = 1'b1; run(3);
        chk("ov_clear", 32'(ovf), 32'd0);

        // SW edge during WAIT for ch1 with cnt=7
        sw_v = 1'b0; run(2);
        for (int i = 0; i < 7; i++) push(1, 8'(8'h40 + i));
        drain(60);
        push(1, 8'h77);
        log_clear();
        wait_grant(10);
        sw_v = 1'b1;
        drain(20);
        push(1, 8'h78);
        drain(20);
        chk("sw_writes", 32'(wn), 32'd2);
        chk("sw_old_addr", 32'(wlog_addr[0]), 32'd71);
        chk("sw_old_bank", 32'(wlog_bank[0]), 32'd1);
        chk("sw_new_addr", 32'(wlog_addr[1]), 32'd64);
        chk("sw_new_bank", 32'(wlog_bank[1]), 32'd0);

        // disabled channel is never granted
        en_v = 5'b10111;
        log_clear();
        push(3, 8'h33); push(3, 8'h34);
        push(0, 8'h01); push(0, 8'h02);
        run(40);
        cnt0 = 0; cnt3 = 0;
        for (int k = 0; k < gn; k++) begin
            if (glog_ch[k] == 0) cnt0++;
            if (glog_ch[k] == 3) cnt3++;
        end
        chk("en_ch3_grants", 32'(cnt3), 32'd0);
        chk("en_ch0_grants", 32'(cnt0), 32'd2);
        chk("en_ch3_occ", 32'(occ(3)), 32'd2);
        en_v = '1;
        drain(50);

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                ch = $urandom_range(0, CH - 1);
                if (occ(ch) < 200) push(ch, 8'($urandom));
            end
            if ($urandom_range(0, 299) == 0) begin
                ch = $urandom_range(0, CH - 1);
                for (int i = 0; i < 40; i++) if (occ(ch) < 200) push(ch, 8'($urandom));
            end
            if ($urandom_range(0, 49) == 0) en_v = CH'($urandom);
            if ($urandom_range(0, 149) == 0) sw_v = ~sw_v;
            tick();
        end
        en_v = '1;
        drain(3000);

        // asynchronous reset in the middle of WAIT
        push(4, 8'h3C);
        wait_grant(10);
        @(posedge clk);
        #2;
        chk("ar_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        rst_v = 1'b0;
        #1;
        chk("ar_rdreq", 32'(rdreq), 32'd0);
        chk("ar_we", 32'(WE), 32'd0);
        chk("ar_waddr", 32'(wAddr), 32'd0);
        chk("ar_word", 32'(orbWord), 32'd0);
        chk("ar_bank", 32'(bank), 32'd0);
        chk("ar_ovf", 32'(ovf), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        env_reset();
        m_reset();
        sw_v = 1'b0;
        run(2);
        rst_v = 1'b1;
        run(3);
        log_clear();
        push(0, 8'hFF);
        drain(20);
        chk("post_rst_addr", 32'(wlog_addr[0]), 32'd0);
        chk("post_rst_word", 32'(wlog_word[0]), 32'h7F8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
